keystream_xor_byte: RTL and testbench

KEYSTREAM_XOR_BYTE -- requirements
Module: keystream_xor_byte

---
 rtl/trivium_pkg.sv | 5 +
 rtl/ks_deserializer.sv | 36 +++
 rtl/keystream_xor_byte.sv | 66 ++++++
 tb/tb_keystream_xor_byte.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// trivium_pkg: shared state encoding and default width for the keystream XOR block
package trivium_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {WAIT_WARM, COLLECT, KEY_FULL} ks_state_e;
endpackage

// File: rtl/ks_deserializer.sv
// ks_deserializer: packs serial keystream bits into a key word, first bit into bit 0
module ks_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] key_o,
  output logic             full_o
);
  localparam int IW = $clog2(WIDTH);
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             last;
  assign last   = idx_q == IW'(WIDTH - 1);
  // full_o flags the edge that captures the final bit, so the parent can change state on it
  assign full_o = en_i && !clr_i && last;
  assign key_o  = key_q;
  always_comb begin
    idx_d = clr_i ? '0 : !en_i ? idx_q : last ? '0 : idx_q + 1'b1;
    key_d = key_q;
    if (clr_i) key_d = '0;
    else if (en_i) key_d[idx_q] = bit_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      key_q <= '0;
    end else begin
      idx_q <= idx_d;
      key_q <= key_d;
    end
  end
endmodule

// File: rtl/keystream_xor_byte.sv
// keystream_xor_byte: XORs plaintext words with keystream words built bit-serially from a generator
module keystream_xor_byte
  import trivium_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ks_warm,
  input  logic             ks_bit,
  output logic             ks_en,
  input  logic             pt_valid,
  input  logic [WIDTH-1:0] pt_data,
  output logic             pt_ready,
  output logic             ct_valid,
  output logic [WIDTH-1:0] ct_data,
  input  logic             ct_ready,
  output logic [CNT_W-1:0] word_cnt
);
  ks_state_e        state_q, state_d;
  logic             ct_valid_q, ct_valid_d;
  logic [WIDTH-1:0] ct_data_q, ct_data_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0] key;
  logic             key_full, pt_hs, ct_hs;
  ks_deserializer #(.WIDTH(WIDTH)) u_deser (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!ks_warm),
    .en_i   (ks_en),
    .bit_i  (ks_bit),
    .key_o  (key),
    .full_o (key_full)
  );
  assign ks_en    = state_q == COLLECT;
  assign pt_ready = state_q == KEY_FULL && (!ct_valid_q || ct_ready);
  assign pt_hs    = pt_valid && pt_ready;
  assign ct_hs    = ct_valid_q && ct_ready;
  assign ct_valid = ct_valid_q;
  assign ct_data  = ct_data_q;
  assign word_cnt = word_cnt_q;
  // losing warm-up overrides everything; a pending ciphertext word survives it
  always_comb begin
    state_d    = !ks_warm ? WAIT_WARM :
                 state_q == WAIT_WARM ? COLLECT :
                 state_q == COLLECT ? (key_full ? KEY_FULL : COLLECT) :
                 pt_hs ? COLLECT : KEY_FULL;
    ct_valid_d = pt_hs ? 1'b1 : ct_hs ? 1'b0 : ct_valid_q;
    ct_data_d  = pt_hs ? pt_data ^ key : ct_data_q;
    word_cnt_d = word_cnt_q + CNT_W'(ct_hs);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WAIT_WARM;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      word_cnt_q <= word_cnt_d;
    end
  end
endmodule

// File: tb/tb_keystream_xor_byte.sv
// tb_keystream_xor_byte: vector table, directed corner cases and random traffic against a queue-based model
module tb_keystream_xor_byte;
  localparam int W = 8;
  logic         clk = 0, rst = 0;
  logic         ks_warm = 0, ks_bit = 0, pt_valid = 0, ct_ready = 0;
  logic [W-1:0] pt_data = 0;
  logic         ks_en, pt_ready, ct_valid;
  logic [W-1:0] ct_data;
  logic [15:0]  word_cnt;
  int checks = 0, failures = 0;

  keystream_xor_byte dut (
    .clk(clk), .rst(rst), .ks_warm(ks_warm), .ks_bit(ks_bit), .ks_en(ks_en),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // reference model: keystream bits gathered so far, pending ciphertext, handoff count
  logic         m_active;
  logic         m_bits[$];
  logic         m_v;
  logic [W-1:0] m_d;
  logic [15:0]  m_cnt;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_active = 0;
    m_bits.delete();
    m_v = 0;
    m_d = 0;
    m_cnt = 0;
  endfunction

  task automatic do_reset();
    rst = 0;
    ks_warm = 0; ks_bit = 0; pt_valid = 0; pt_data = 0; ct_ready = 0;
    #1;
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_ks_en", ks_en, 0);
    chk("rst_pt_ready", pt_ready, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic cycle(input logic w, input logic b, input logic pv, input logic [W-1:0] pd, input logic cr);
    logic e_en, e_rdy;
    logic [W-1:0] key;
    ks_warm = w; ks_bit = b; pt_valid = pv; pt_data = pd; ct_ready = cr;
    #1;
    e_en  = m_active && m_bits.size() < W;
    e_rdy = m_bits.size() == W && (!m_v || cr);
    chk("m_ks_en", ks_en, e_en);
    chk("m_pt_ready", pt_ready, e_rdy);
    chk("m_ct_valid", ct_valid, m_v);
    chk("m_ct_data", ct_data, m_d);
    chk("m_word_cnt", word_cnt, m_cnt);
    if (m_v && cr) m_cnt++;
    if (e_en) m_bits.push_back(b);
    if (pv && e_rdy) begin
      key = 0;
      foreach (m_bits[i]) key[i] = m_bits[i];
      m_d = pd ^ key;
      m_v = 1;
      m_bits.delete();
    end else if (m_v && cr) m_v = 0;
    if (!w) begin
      m_active = 0;
      m_bits.delete();
    end else m_active = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic w, b, pv;
    logic [W-1:0] pd;
    logic cr, en, rdy, v;
    logic [W-1:0] d;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic w, logic b, logic pv, logic [W-1:0] pd, logic cr,
                              logic en, logic rdy, logic v, logic [W-1:0] d, logic [15:0] cnt);
    vec_t r;
    r.w = w; r.b = b; r.pv = pv; r.pd = pd; r.cr = cr;
    r.en = en; r.rdy = rdy; r.v = v; r.d = d; r.cnt = cnt;
    tbl.push_back(r);
  endfunction

  initial begin
    logic [W-1:0] pat;
    logic [31:0] r;
    int en_cnt, last_v, nvalid;
    pat = 8'b1010_0101;

    // keystream 1,0,1,0,0,1,0,1 -> key A5; stall, simultaneous handoff, drain
    add(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < W; i++) add(1, pat[i], 0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
    add(1, 0, 1, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < W; i++) add(1, pat[i], 0, 8'h00, 0, 1, 0, 1, 8'hA5, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 1, 8'hFF, 0, 0, 0, 1, 8'hA5, 0);
    add(1, 0, 1, 8'hFF, 1, 0, 1, 1, 8'hA5, 0);
    for (int i = 0; i < W; i++) add(1, pat[i], 0, 8'h00, 0, 1, 0, 1, 8'h5A, 1);
    add(1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h5A, 1);
    add(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h5A, 2);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1, 8'h33, 1);
      chk("idle_ks_en", ks_en, 0);
      chk("idle_pt_ready", pt_ready, 0);
      chk("idle_ct_valid", ct_valid, 0);
    end

    do_reset();
    foreach (tbl[k]) begin
      ks_warm = tbl[k].w; ks_bit = tbl[k].b; pt_valid = tbl[k].pv;
      pt_data = tbl[k].pd; ct_ready = tbl[k].cr;
      #1;
      chk("tbl_ks_en", ks_en, tbl[k].en);
      chk("tbl_pt_ready", pt_ready, tbl[k].rdy);
      chk("tbl_ct_valid", ct_valid, tbl[k].v);
      chk("tbl_ct_data", ct_data, tbl[k].d);
      chk("tbl_word_cnt", word_cnt, tbl[k].cnt);
      cycle(tbl[k].w, tbl[k].b, tbl[k].pv, tbl[k].pd, tbl[k].cr);
    end

    // continuous traffic: one word per 9 cycles, 8 keystream bits per word
    do_reset();
    en_cnt = 0; last_v = -1; nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      ks_warm = 1; ks_bit = 1; pt_valid = 1; pt_data = 0; ct_ready = 1;
      #1;
      if (ct_valid) begin
        chk("stream_ct_data", ct_data, 8'hFF);
        if (last_v >= 0) begin
          chk("stream_period", 64'(c - last_v), 9);
          chk("stream_ks_en_per_word", 64'(en_cnt), 8);
        end
        last_v = c; en_cnt = 0; nvalid++;
      end
      en_cnt += int'(ks_en);
      cycle(1, 1, 1, 8'h00, 1);
    end
    chk("stream_words", 64'(nvalid), 4);

    // warm-up lost after 4 bits: the next word must come from 8 fresh bits
    do_reset();
    cycle(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 8'h00, 0);
    cycle(0, 1, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < W; i++) cycle(1, pat[i], 0, 8'h00, 0);
    cycle(1, 0, 1, 8'h00, 1);
    chk("rewarm_ct_valid", ct_valid, 1);
    chk("rewarm_ct_data", ct_data, 8'hA5);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      cycle(r[5:0] != 0, r[6], r[7] | r[8], W'(r[23:16]), r[9] | r[10]);
    end

    // reset with a pending word after nonzero handoffs
    for (int c = 0; c < 20; c++) cycle(1, 1, 1, 8'h0F, 0);
    chk("pre_rst_ct_valid", ct_valid, 1);
    do_reset();
    cycle(1, 0, 0, 8'h00, 1);
    chk("post_rst_ct_valid", ct_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
